// File: rtl/icache_nway_refill_if.sv
// rtl/icache_nway_refill_if.sv - fetch-side and AXI read-bus signal bundle for the refill cache
interface icache_nway_refill_if;
   logic [31:0] cpu_addr;
   logic        cpu_read;
   logic        cpu_uncached;
   logic        cpu_hitinvalidate;
   logic        cpu_addr_illegal;
   logic [31:0] cpu_rddata;
   logic        cpu_stall;
   logic [31:0] AXI_addr;
   logic        AXI_addr_valid;
   logic        AXI_rd_addr_clear;
   logic        AXI_we;
   logic [2:0]  AXI_size;
   logic [7:0]  AXI_lens;
   logic        AXI_rd_rready;
   logic        AXI_rd_dready;
   logic [31:0] AXI_rd_data;
   logic        AXI_rd_last;

   // the cache serves fetch requests and drives the read bus
   modport slave (
      input  cpu_addr, cpu_read, cpu_uncached, cpu_hitinvalidate, cpu_addr_illegal,
      input  AXI_rd_addr_clear, AXI_rd_dready, AXI_rd_data, AXI_rd_last,
      output cpu_rddata, cpu_stall,
      output AXI_addr, AXI_addr_valid, AXI_we, AXI_size, AXI_lens, AXI_rd_rready
   );

   modport master (
      output cpu_addr, cpu_read, cpu_uncached, cpu_hitinvalidate, cpu_addr_illegal,
      output AXI_rd_addr_clear, AXI_rd_dready, AXI_rd_data, AXI_rd_last,
      input  cpu_rddata, cpu_stall,
      input  AXI_addr, AXI_addr_valid, AXI_we, AXI_size, AXI_lens, AXI_rd_rready
   );
endinterface

// File: rtl/icache_nway_refill.sv
// rtl/icache_nway_refill.sv - N-way read-only instruction cache with AXI line refill FSM
module icache_nway_refill #(
   parameter int LINE_WIDTH  = 6,
   parameter int INDEX_WIDTH = 7,
   parameter int NUM_WAYS    = 2
) (
   input logic               clk,
   input logic               rst,
   icache_nway_refill_if.slave bus
);
   localparam int WORDS = 2 ** (LINE_WIDTH - 2);
   localparam int SETS  = 2 ** INDEX_WIDTH;
   localparam int TAG_W = 32 - INDEX_WIDTH - LINE_WIDTH;
   localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int CNT_W = LINE_WIDTH - 2;
   localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_WIDTH) - 32'd1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_REFILL, S_DONE} state_t;

   logic [31:0]      r_data  [NUM_WAYS][SETS][WORDS];
   logic [TAG_W-1:0] r_tag   [NUM_WAYS][SETS];
   logic [SETS-1:0]  r_valid [NUM_WAYS];

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_full;
   logic [WAY_W-1:0]   r_rr;
   logic [WAY_W-1:0]   r_victim;
   logic [INDEX_WIDTH-1:0] r_idx;
   logic [TAG_W-1:0]   r_ltag;
   logic               r_uncached;
   logic [31:0]        r_rdbuf;
   logic [31:0]        r_axi_addr;
   logic [7:0]         r_axi_lens;
   logic               r_axi_av;
   logic               r_axi_rready;

   logic [INDEX_WIDTH-1:0] w_index;
   logic [TAG_W-1:0]       w_tag;
   logic [CNT_W-1:0]       w_word;
   logic [NUM_WAYS-1:0]    w_hit_vec;
   logic                   w_hit;
   logic [31:0]            w_hit_data;
   logic [WAY_W-1:0]       w_victim;
   logic                   w_inval, w_rd, w_unc_req, w_miss;
   logic                   w_stall;
   logic [31:0]            w_rddata;
   logic                   w_data_we, w_tag_we;

   assign w_index = bus.cpu_addr[LINE_WIDTH+INDEX_WIDTH-1:LINE_WIDTH];
   assign w_tag   = bus.cpu_addr[31:LINE_WIDTH+INDEX_WIDTH];
   assign w_word  = bus.cpu_addr[LINE_WIDTH-1:2];

   // Victim prefers the lowest-numbered invalid way before falling back to round-robin
   always_comb begin
      w_hit_vec  = '0;
      w_hit_data = '0;
      w_victim   = r_rr;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (r_valid[w][w_index] && (r_tag[w][w_index] == w_tag)) begin
            w_hit_vec[w] = 1'b1;
            w_hit_data   = w_hit_data | r_data[w][w_index][w_word];
         end
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w][w_index]) w_victim = WAY_W'(w);
      end
   end

   assign w_hit     = |w_hit_vec;
   assign w_inval   = (r_state == S_IDLE) && !bus.cpu_addr_illegal && bus.cpu_hitinvalidate;
   assign w_rd      = (r_state == S_IDLE) && !bus.cpu_addr_illegal && !bus.cpu_hitinvalidate && bus.cpu_read;
   assign w_unc_req = w_rd && bus.cpu_uncached;
   assign w_miss    = w_rd && !bus.cpu_uncached && !w_hit;

   always_comb begin
      w_stall  = 1'b0;
      w_rddata = '0;
      if (rst) begin
         case (r_state)
            S_IDLE: begin
               if (!bus.cpu_addr_illegal && bus.cpu_read)
                  w_stall = bus.cpu_hitinvalidate || bus.cpu_uncached || !w_hit;
               if (w_rd && !bus.cpu_uncached && w_hit) w_rddata = w_hit_data;
            end
            S_ADDR, S_REFILL: w_stall = 1'b1;
            S_DONE: begin
               w_stall = !r_uncached;
               if (r_uncached) w_rddata = r_rdbuf;
            end
            default: w_stall = 1'b0;
         endcase
      end
   end

   assign w_data_we = (r_state == S_REFILL) && bus.AXI_rd_dready && !r_full && !r_uncached;
   assign w_tag_we  = (r_state == S_DONE) && !r_uncached;

   always_ff @(posedge clk) begin
      if (w_data_we) r_data[r_victim][r_idx][r_cnt] <= bus.AXI_rd_data;
      if (w_tag_we)  r_tag[r_victim][r_idx] <= r_ltag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int w = 0; w < NUM_WAYS; w++) r_valid[w] <= '0;
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_full       <= 1'b0;
         r_rr         <= '0;
         r_victim     <= '0;
         r_idx        <= '0;
         r_ltag       <= '0;
         r_uncached   <= 1'b0;
         r_rdbuf      <= '0;
         r_axi_addr   <= '0;
         r_axi_lens   <= '0;
         r_axi_av     <= 1'b0;
         r_axi_rready <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_inval) begin
                  for (int w = 0; w < NUM_WAYS; w++)
                     if (w_hit_vec[w]) r_valid[w][w_index] <= 1'b0;
               end else if (w_unc_req) begin
                  r_uncached <= 1'b1;
                  r_axi_addr <= bus.cpu_addr & ~32'h3;
                  r_axi_lens <= 8'd0;
                  r_axi_av   <= 1'b1;
                  r_state    <= S_ADDR;
               end else if (w_miss) begin
                  // victim is invalidated now so a short or aborted refill never leaves a stale hit
                  r_uncached <= 1'b0;
                  r_victim   <= w_victim;
                  r_rr       <= (r_rr == WAY_W'(NUM_WAYS - 1)) ? '0 : r_rr + 1'b1;
                  r_idx      <= w_index;
                  r_ltag     <= w_tag;
                  r_valid[w_victim][w_index] <= 1'b0;
                  r_axi_addr <= bus.cpu_addr & LINE_MASK;
                  r_axi_lens <= 8'(WORDS - 1);
                  r_axi_av   <= 1'b1;
                  r_state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (bus.AXI_rd_addr_clear) begin
                  r_axi_av     <= 1'b0;
                  r_axi_rready <= 1'b1;
                  r_cnt        <= '0;
                  r_full       <= 1'b0;
                  r_state      <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (bus.AXI_rd_dready) begin
                  if (!r_full) begin
                     if (r_uncached && (r_cnt == '0)) r_rdbuf <= bus.AXI_rd_data;
                     if (r_cnt == CNT_W'(WORDS - 1)) r_full <= 1'b1;
                     else r_cnt <= r_cnt + 1'b1;
                  end
                  if (bus.AXI_rd_last) begin
                     r_axi_rready <= 1'b0;
                     r_state      <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (!r_uncached) r_valid[r_victim][r_idx] <= r_full;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cpu_stall      = w_stall;
   assign bus.cpu_rddata     = w_rddata;
   assign bus.AXI_addr       = r_axi_addr;
   assign bus.AXI_addr_valid = r_axi_av;
   assign bus.AXI_lens       = r_axi_lens;
   assign bus.AXI_rd_rready  = r_axi_rready;
   assign bus.AXI_we         = 1'b0;
   assign bus.AXI_size       = 3'b010;
endmodule
